spatial_sram_scheduler: RTL and testbench
=========================================

Name: spatial_sram_scheduler

Overview:
- Shares one wide item-memory/projection-memory read port between the three modality accumulators of the spatial encoder.
- Each memory row holds three fields for one channel: iM, projM_neg and projM_pos.
- Takes per-modality fetch requests plus the encoder's channel counter, arbitrates round-robin, and issues reads at the modality's base row.
- Captures return data into per-modality holding registers and raises the per-modality SRAM-valid flags that the encoder waits on.

Parameters:
HV_DIMENSION, 2000, hypervector width in bits
CH_MOD1, 32, channel count of modality 1 (rows 0..31)
CH_MOD2, 109, channel count of modality 2 (rows 32..140)
CH_MOD3, 214, channel count of modality 3 (rows 141..354)
CHAN_W, 8, width of the channel counter input
ADDR_W, 9, memory row address width
RD_LATENCY, 2, cycles from MemEn_SO high to MemRdData_DI valid (1..4)

Ports:
Clk_CI  in  1  clock
Reset_RI  in  1  reset, asynchronous, active-high
Req_SI  in  3  bit k-1 = modality k wants the row for ChanAddr_DI (encoder spatial_ready_k)
ChanAddr_DI  in  CHAN_W  current channel index, common to all modalities
MemEn_SO  out  1  read strobe, one row per cycle
MemAddr_DO  out  ADDR_W  row address = base_k + ChanAddr_DI
MemRdData_DI  in  3*HV_DIMENSION  {iM, projM_neg, projM_pos}, MSB-first
IM_mod{1,2,3}_DO  out  HV_DIMENSION each  held iM row per modality
ProjNeg_mod{1,2,3}_DO  out  HV_DIMENSION each  held projM_neg row
ProjPos_mod{1,2,3}_DO  out  HV_DIMENSION each  held projM_pos row
SramValid_SO  out  3  bit k-1 = modality k holding registers match ChanAddr_DI
Busy_SO  out  1  any modality PENDING or any read in flight

Behaviour:
- Reset clears all state; outputs at reset:
  - Slot states: all EMPTY; tags 0.
  - Holding registers: 0.
  - In-flight pipeline: cleared.
  - Round-robin pointer: modality 1.
  - MemEn_SO = 0, SramValid_SO = 000, Busy_SO = 0.
- Slot states per modality k: EMPTY, PENDING, INFLIGHT, FULL. Each slot has a tag register of CHAN_W bits.
- A need is raised when Req_k=1, ChanAddr_DI < CH_MODk, and NOT (state in {INFLIGHT, FULL} with tag == ChanAddr_DI).
  - On a need, the slot goes to PENDING.
  - If the slot was INFLIGHT with a different tag, the outstanding read is marked stale.
- Arbiter: each cycle, grant one PENDING modality.
  - Search order starts at the pointer; the pointer moves to granted+1 (mod 3).
  - Grant is combinational in the same cycle: MemEn_SO=1, MemAddr_DO = base_k + ChanAddr_DI (base1=0, base2=CH_MOD1, base3=CH_MOD1+CH_MOD2), zero-extended to ADDR_W.
  - At the cycle edge: tag := ChanAddr_DI, state := INFLIGHT, and {valid, id, stale=0} is pushed into a RD_LATENCY-deep pipeline.
- Return: in cycle t+RD_LATENCY, MemRdData_DI is valid.
  - A non-stale entry loads that modality's three holding registers at the edge; the slot goes to FULL.
  - A stale entry is discarded; the slot remains PENDING.
- SramValid_SO[k-1] = (state_k==FULL) & (tag_k==ChanAddr_DI) & Req_k. This is combinational, so a stale row is never flagged.
- Latency: need first seen in cycle t with no contention -> SramValid high in cycle t+RD_LATENCY+1. With contention, add 1 cycle per earlier grant.
- Req_k low: no new need; FULL data and tag are retained. Re-raising Req_k for the same address gives SramValid in the same cycle, with no read.
- ChanAddr_DI >= CH_MODk: no fetch; SramValid_SO[k-1]=0. The slot is left unchanged.
- Slot FULL and the tag mismatches a new need: the slot goes to PENDING; holding registers keep the old data until overwritten.
- Mismatch and return in the same cycle: the return is treated as stale and discarded; the slot goes to PENDING.
- At most one grant per cycle. Multiple modalities may be INFLIGHT at once, one entry per pipeline stage.
- Reset asserted mid-read: in-flight returns are dropped; there are no writes after reset release until new grants.
- Busy_SO = any PENDING | any pipeline valid.

Test Plan:
- Reset released, ChanAddr=0, Req=111, RD_LATENCY=2 -> grants in cycles 0,1,2 at rows 0, 32, 141; SramValid 001 at cycle 3, 011 at cycle 4, 111 at cycle 5; Busy low at cycle 5.
- All FULL at channel 5; ChanAddr steps to 6 -> SramValid 000 the same cycle; three reads at rows 6, 38, 147; SramValid=111 three cycles after the last grant.
- ChanAddr=40, Req=111 -> modality 1 gets no read and SramValid[0]=0; modalities 2 and 3 fetch rows 72 and 181.
- Modality 3 INFLIGHT for channel 10; ChanAddr changes to 11 before the return -> the row-151 return is discarded; a new read at row 152 follows; SramValid[2] rises only for tag 11.
- Req drops to 000 with all FULL at channel 20, then returns to 111 -> SramValid=111 the same cycle; MemEn_SO stays 0.
- Reset pulsed while two reads are in flight -> SramValid=000 and holding registers=0; no register update when the dropped data arrives.

Source files
------------

// File: rtl/spatial_sram_scheduler_if.sv
// Bus bundle between the spatial encoder / item-memory side and the
// spatial SRAM scheduler.
//   Req_SI        per-modality fetch request (bit k-1 = modality k)
//   ChanAddr_DI   channel index shared by all modalities
//   MemEn_SO      memory read strobe
//   MemAddr_DO    memory row address
//   MemRdData_DI  returned row {iM, projM_neg, projM_pos}
//   IM/ProjNeg/ProjPos_mod{1,2,3}_DO  per-modality holding registers
//   SramValid_SO  per-modality "holding registers match channel" flags
//   Busy_SO       work outstanding
// modport slave is the scheduler; modport master is the encoder/memory side.
interface spatial_sram_scheduler_if #(
    parameter int HV_DIMENSION = 2000,
    parameter int CHAN_W       = 8,
    parameter int ADDR_W       = 9
);
    logic [2:0]                  Req_SI;
    logic [CHAN_W-1:0]           ChanAddr_DI;
    logic                        MemEn_SO;
    logic [ADDR_W-1:0]           MemAddr_DO;
    logic [3*HV_DIMENSION-1:0]   MemRdData_DI;
    logic [HV_DIMENSION-1:0]     IM_mod1_DO;
    logic [HV_DIMENSION-1:0]     IM_mod2_DO;
    logic [HV_DIMENSION-1:0]     IM_mod3_DO;
    logic [HV_DIMENSION-1:0]     ProjNeg_mod1_DO;
    logic [HV_DIMENSION-1:0]     ProjNeg_mod2_DO;
    logic [HV_DIMENSION-1:0]     ProjNeg_mod3_DO;
    logic [HV_DIMENSION-1:0]     ProjPos_mod1_DO;
    logic [HV_DIMENSION-1:0]     ProjPos_mod2_DO;
    logic [HV_DIMENSION-1:0]     ProjPos_mod3_DO;
    logic [2:0]                  SramValid_SO;
    logic                        Busy_SO;

    modport master (
        output Req_SI, ChanAddr_DI, MemRdData_DI,
        input  MemEn_SO, MemAddr_DO,
        input  IM_mod1_DO, IM_mod2_DO, IM_mod3_DO,
        input  ProjNeg_mod1_DO, ProjNeg_mod2_DO, ProjNeg_mod3_DO,
        input  ProjPos_mod1_DO, ProjPos_mod2_DO, ProjPos_mod3_DO,
        input  SramValid_SO, Busy_SO
    );

    modport slave (
        input  Req_SI, ChanAddr_DI, MemRdData_DI,
        output MemEn_SO, MemAddr_DO,
        output IM_mod1_DO, IM_mod2_DO, IM_mod3_DO,
        output ProjNeg_mod1_DO, ProjNeg_mod2_DO, ProjNeg_mod3_DO,
        output ProjPos_mod1_DO, ProjPos_mod2_DO, ProjPos_mod3_DO,
        output SramValid_SO, Busy_SO
    );
endinterface

// File: rtl/spatial_sram_scheduler.sv
// Spatial SRAM scheduler: shares one wide iM/projM read port between the
// three modality accumulators of the spatial encoder. Each modality owns a
// slot (EMPTY/PENDING/INFLIGHT/FULL) with a channel tag; a round-robin
// arbiter issues one row read per cycle at base_k + channel, and returning
// rows are captured into per-modality holding registers.
// Ports:
//   Clk_CI    clock
//   Reset_RI  asynchronous active-high reset
//   bus       spatial_sram_scheduler_if.slave (requests, memory port,
//             holding registers, SramValid_SO, Busy_SO)
module spatial_sram_scheduler #(
    parameter int HV_DIMENSION = 2000,
    parameter int CH_MOD1      = 32,
    parameter int CH_MOD2      = 109,
    parameter int CH_MOD3      = 214,
    parameter int CHAN_W       = 8,
    parameter int ADDR_W       = 9,
    parameter int RD_LATENCY   = 2
) (
    input  logic                     Clk_CI,
    input  logic                     Reset_RI,
    spatial_sram_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {EMPTY, PENDING, INFLIGHT, FULL} slot_state_t;

    localparam int LAST = RD_LATENCY - 1;

    slot_state_t             state_q [3];
    logic [CHAN_W-1:0]       tag_q   [3];
    logic [HV_DIMENSION-1:0] im_q    [3];
    logic [HV_DIMENSION-1:0] neg_q   [3];
    logic [HV_DIMENSION-1:0] pos_q   [3];
    logic [1:0]              ptr_q;

    logic                    pipe_valid_q [RD_LATENCY];
    logic [1:0]              pipe_id_q    [RD_LATENCY];
    logic                    pipe_stale_q [RD_LATENCY];

    logic [2:0]              in_range;
    logic [2:0]              need;
    logic [2:0]              eligible;
    logic [2:0]              mark_stale;
    logic [2:0]              sram_valid;
    logic                    gnt_valid;
    logic [1:0]              gnt_id;
    logic [1:0]              cand;
    logic                    ret_load;
    logic [1:0]              ret_id;
    logic                    any_pending;
    logic                    any_pipe;

    function automatic logic [31:0] limit_of(input logic [1:0] k);
        case (k)
            2'd0:    return 32'(CH_MOD1);
            2'd1:    return 32'(CH_MOD2);
            default: return 32'(CH_MOD3);
        endcase
    endfunction

    function automatic logic [ADDR_W-1:0] base_of(input logic [1:0] k);
        case (k)
            2'd0:    return '0;
            2'd1:    return ADDR_W'(CH_MOD1);
            default: return ADDR_W'(CH_MOD1 + CH_MOD2);
        endcase
    endfunction

    // Need / eligibility / valid flags per modality.
    always_comb begin
        in_range   = '0;
        need       = '0;
        eligible   = '0;
        mark_stale = '0;
        sram_valid = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            in_range[k] = 32'(bus.ChanAddr_DI) < limit_of(2'(k));
            need[k] = bus.Req_SI[k] & in_range[k] &
                      ~(((state_q[k] == INFLIGHT) || (state_q[k] == FULL)) &&
                        (tag_q[k] == bus.ChanAddr_DI));
            eligible[k] = in_range[k] & (need[k] | (state_q[k] == PENDING));
            // A need while INFLIGHT implies a tag mismatch: the outstanding
            // read belongs to an old channel and must not be captured.
            mark_stale[k] = need[k] & (state_q[k] == INFLIGHT);
            sram_valid[k] = (state_q[k] == FULL) && (tag_q[k] == bus.ChanAddr_DI) &&
                            bus.Req_SI[k];
        end
    end

    // Round-robin grant starting at ptr_q; suppressed while in reset.
    always_comb begin
        gnt_valid = 1'b0;
        gnt_id    = 2'd0;
        cand      = 2'd0;
        for (int unsigned n = 0; n < 3; n++) begin
            cand = 2'((32'(ptr_q) + n) % 3);
            if (!Reset_RI && !gnt_valid && eligible[cand]) begin
                gnt_valid = 1'b1;
                gnt_id    = cand;
            end
        end
    end

    always_comb begin
        any_pending = 1'b0;
        any_pipe    = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            any_pending = any_pending | (state_q[k] == PENDING);
        end
        for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            any_pipe = any_pipe | pipe_valid_q[i];
        end
    end

    // A return colliding with a same-cycle tag mismatch is dropped as stale.
    assign ret_id   = pipe_id_q[LAST];
    assign ret_load = pipe_valid_q[LAST] & ~pipe_stale_q[LAST] & ~mark_stale[ret_id];

    always_ff @(posedge Clk_CI or posedge Reset_RI) begin
        if (Reset_RI) begin
            for (int unsigned k = 0; k < 3; k++) begin
                state_q[k] <= EMPTY;
                tag_q[k]   <= '0;
                im_q[k]    <= '0;
                neg_q[k]   <= '0;
                pos_q[k]   <= '0;
            end
            for (int unsigned i = 0; i < RD_LATENCY; i++) begin
                pipe_valid_q[i] <= 1'b0;
                pipe_id_q[i]    <= 2'd0;
                pipe_stale_q[i] <= 1'b0;
            end
            ptr_q <= 2'd0;
        end else begin
            for (int unsigned k = 0; k < 3; k++) begin
                if (gnt_valid && (gnt_id == 2'(k))) begin
                    state_q[k] <= INFLIGHT;
                    tag_q[k]   <= bus.ChanAddr_DI;
                end else if (need[k]) begin
                    state_q[k] <= PENDING;
                end else if (ret_load && (ret_id == 2'(k))) begin
                    state_q[k] <= FULL;
                    im_q[k]    <= bus.MemRdData_DI[3*HV_DIMENSION-1 -: HV_DIMENSION];
                    neg_q[k]   <= bus.MemRdData_DI[2*HV_DIMENSION-1 -: HV_DIMENSION];
                    pos_q[k]   <= bus.MemRdData_DI[HV_DIMENSION-1:0];
                end
            end
            if (gnt_valid) begin
                ptr_q <= (gnt_id == 2'd2) ? 2'd0 : gnt_id + 2'd1;
            end
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                pipe_valid_q[i] <= pipe_valid_q[i-1];
                pipe_id_q[i]    <= pipe_id_q[i-1];
                pipe_stale_q[i] <= pipe_stale_q[i-1] | mark_stale[pipe_id_q[i-1]];
            end
            pipe_valid_q[0] <= gnt_valid;
            pipe_id_q[0]    <= gnt_id;
            pipe_stale_q[0] <= 1'b0;
        end
    end

    assign bus.MemEn_SO        = gnt_valid;
    assign bus.MemAddr_DO      = gnt_valid ? base_of(gnt_id) + ADDR_W'(bus.ChanAddr_DI) : '0;
    assign bus.SramValid_SO    = sram_valid;
    assign bus.Busy_SO         = any_pending | any_pipe;
    assign bus.IM_mod1_DO      = im_q[0];
    assign bus.IM_mod2_DO      = im_q[1];
    assign bus.IM_mod3_DO      = im_q[2];
    assign bus.ProjNeg_mod1_DO = neg_q[0];
    assign bus.ProjNeg_mod2_DO = neg_q[1];
    assign bus.ProjNeg_mod3_DO = neg_q[2];
    assign bus.ProjPos_mod1_DO = pos_q[0];
    assign bus.ProjPos_mod2_DO = pos_q[1];
    assign bus.ProjPos_mod3_DO = pos_q[2];
endmodule

// File: tb/tb_spatial_sram_scheduler.sv
// Testbench for spatial_sram_scheduler: directed stimulus with a memory
// model returning rows two cycles after each read strobe, and a scoreboard
// monitor that checks issued read addresses and captured rows.
module tb_spatial_sram_scheduler;
    localparam int HV     = 2000;
    localparam int CHAN_W = 8;
    localparam int ADDR_W = 9;

    logic clk = 1'b0;
    logic rst;
    int   compared   = 0;
    int   mismatched = 0;

    spatial_sram_scheduler_if #(.HV_DIMENSION(HV), .CHAN_W(CHAN_W), .ADDR_W(ADDR_W)) bus ();

    spatial_sram_scheduler #(
        .HV_DIMENSION(HV), .CH_MOD1(32), .CH_MOD2(109), .CH_MOD3(214),
        .CHAN_W(CHAN_W), .ADDR_W(ADDR_W), .RD_LATENCY(2)
    ) dut (
        .Clk_CI(clk),
        .Reset_RI(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [HV-1:0] row_word(input int row, input int f);
        logic [HV-1:0] w;
        w = '0;
        for (int i = 0; i < HV/32; i++) w[i*32 +: 32] = {8'(f), 8'(i), 16'(row)};
        w[HV-1 -: 16] = {4'(f), 4'hA, 8'(row)};
        return w;
    endfunction

    // Memory model: row read in cycle t is presented during cycle t+2.
    logic              p_en = 1'b0;
    logic [ADDR_W-1:0] p_addr = '0;
    always @(posedge clk) begin
        bus.MemRdData_DI <= p_en ? {row_word(int'(p_addr), 0), row_word(int'(p_addr), 1),
                                    row_word(int'(p_addr), 2)} : '1;
        p_en   <= bus.MemEn_SO;
        p_addr <= bus.MemAddr_DO;
    end

    logic [ADDR_W-1:0] exp_addr_q [$];
    int                exp_row0_q [$];
    int                exp_row1_q [$];
    int                exp_row2_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_hv(input string name, input logic [HV-1:0] act, input logic [HV-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got hi %h lo %h expected hi %h lo %h (t=%0t)", name,
                     act[HV-1 -: 32], act[31:0], exp[HV-1 -: 32], exp[31:0], $time);
        end
    endtask

    task automatic compare_slot(input int k);
        int            row;
        int            sz;
        logic [HV-1:0] im, ng, ps;
        case (k)
            0: begin im = bus.IM_mod1_DO; ng = bus.ProjNeg_mod1_DO; ps = bus.ProjPos_mod1_DO; sz = exp_row0_q.size(); end
            1: begin im = bus.IM_mod2_DO; ng = bus.ProjNeg_mod2_DO; ps = bus.ProjPos_mod2_DO; sz = exp_row1_q.size(); end
            default: begin im = bus.IM_mod3_DO; ng = bus.ProjNeg_mod3_DO; ps = bus.ProjPos_mod3_DO; sz = exp_row2_q.size(); end
        endcase
        if (sz == 0) begin
            compared++;
            mismatched++;
            $display("FAIL sram_valid_mod%0d: unexpected rise, no row expected (t=%0t)", k + 1, $time);
        end else begin
            case (k)
                0:       row = exp_row0_q.pop_front();
                1:       row = exp_row1_q.pop_front();
                default: row = exp_row2_q.pop_front();
            endcase
            check_hv($sformatf("iM_mod%0d_row%0d", k + 1, row), im, row_word(row, 0));
            check_hv($sformatf("projneg_mod%0d_row%0d", k + 1, row), ng, row_word(row, 1));
            check_hv($sformatf("projpos_mod%0d_row%0d", k + 1, row), ps, row_word(row, 2));
        end
    endtask

    // Monitor: every read strobe pops an expected address; every rising
    // SramValid bit pops the row that modality should be holding.
    logic [2:0] prev_valid = '0;
    always @(negedge clk) begin
        if (bus.MemEn_SO === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL read_addr: unexpected read at row %0d, none expected (t=%0t)",
                         bus.MemAddr_DO, $time);
            end else begin
                check("read_addr", 32'(bus.MemAddr_DO), 32'(exp_addr_q.pop_front()));
            end
        end
        for (int k = 0; k < 3; k++) begin
            if (bus.SramValid_SO[k] === 1'b1 && !prev_valid[k]) compare_slot(k);
        end
        prev_valid <= bus.SramValid_SO;
    end

    task automatic cyc(input logic r, input logic [2:0] req, input logic [7:0] ch);
        @(posedge clk);
        #1;
        rst = r;
        bus.Req_SI = req;
        bus.ChanAddr_DI = ch;
        #2;
    endtask

    task automatic expect_triple(input int ch);
        exp_addr_q.push_back(ADDR_W'(ch));
        exp_addr_q.push_back(ADDR_W'(32 + ch));
        exp_addr_q.push_back(ADDR_W'(141 + ch));
        exp_row0_q.push_back(ch);
        exp_row1_q.push_back(32 + ch);
        exp_row2_q.push_back(141 + ch);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        bus.Req_SI = 3'b000;
        bus.ChanAddr_DI = '0;
        repeat (3) @(posedge clk);
        #3;
        check("reset_valid", 32'(bus.SramValid_SO), 32'h0);
        check("reset_memen", 32'(bus.MemEn_SO), 32'h0);
        check("reset_busy", 32'(bus.Busy_SO), 32'h0);
        check_hv("reset_im1", bus.IM_mod1_DO, '0);
        check_hv("reset_pos3", bus.ProjPos_mod3_DO, '0);

        // Startup fetch at channel 0: grants rows 0, 32, 141 in cycles 0..2.
        expect_triple(0);
        cyc(0, 3'b111, 8'd0);  check("t1_c0_valid", 32'(bus.SramValid_SO), 32'h0);
        cyc(0, 3'b111, 8'd0);  check("t1_c1_busy", 32'(bus.Busy_SO), 32'h1);
        cyc(0, 3'b111, 8'd0);  check("t1_c2_valid", 32'(bus.SramValid_SO), 32'h0);
        cyc(0, 3'b111, 8'd0);  check("t1_c3_valid", 32'(bus.SramValid_SO), 32'h1);
        cyc(0, 3'b111, 8'd0);  check("t1_c4_valid", 32'(bus.SramValid_SO), 32'h3);
        cyc(0, 3'b111, 8'd0);  check("t1_c5_valid", 32'(bus.SramValid_SO), 32'h7);
        check("t1_c5_busy", 32'(bus.Busy_SO), 32'h0);

        // Fill at channel 5.
        expect_triple(5);
        cyc(0, 3'b111, 8'd5);  check("ch5_c0_valid", 32'(bus.SramValid_SO), 32'h0);
        repeat (5) cyc(0, 3'b111, 8'd5);
        check("ch5_c5_valid", 32'(bus.SramValid_SO), 32'h7);

        // Step to channel 6: flags drop immediately, rows 6, 38, 147.
        expect_triple(6);
        cyc(0, 3'b111, 8'd6);  check("ch6_c0_valid", 32'(bus.SramValid_SO), 32'h0);
        repeat (2) cyc(0, 3'b111, 8'd6);
        cyc(0, 3'b111, 8'd6);  check("ch6_c3_valid", 32'(bus.SramValid_SO), 32'h1);
        cyc(0, 3'b111, 8'd6);  check("ch6_c4_valid", 32'(bus.SramValid_SO), 32'h3);
        cyc(0, 3'b111, 8'd6);  check("ch6_c5_valid", 32'(bus.SramValid_SO), 32'h7);
        check("ch6_c5_memen", 32'(bus.MemEn_SO), 32'h0);

        // Channel 40 is out of range for modality 1: rows 72, 181 only.
        exp_addr_q.push_back(ADDR_W'(72));
        exp_addr_q.push_back(ADDR_W'(181));
        exp_row1_q.push_back(72);
        exp_row2_q.push_back(181);
        cyc(0, 3'b111, 8'd40); check("ch40_c0_valid", 32'(bus.SramValid_SO), 32'h0);
        repeat (2) cyc(0, 3'b111, 8'd40);
        cyc(0, 3'b111, 8'd40); check("ch40_c3_valid", 32'(bus.SramValid_SO), 32'h2);
        cyc(0, 3'b111, 8'd40); check("ch40_c4_valid", 32'(bus.SramValid_SO), 32'h6);
        check_hv("ch40_im1_retained", bus.IM_mod1_DO, row_word(6, 0));
        cyc(0, 3'b111, 8'd40); check("ch40_c5_busy", 32'(bus.Busy_SO), 32'h0);

        // Modality 3 in flight for channel 10, channel moves to 11: the
        // row-151 return is discarded and row 152 is fetched.
        exp_addr_q.push_back(ADDR_W'(151));
        exp_addr_q.push_back(ADDR_W'(152));
        exp_row2_q.push_back(152);
        cyc(0, 3'b100, 8'd10); check("stale_c0_valid", 32'(bus.SramValid_SO), 32'h0);
        cyc(0, 3'b100, 8'd11); check("stale_c1_memen", 32'(bus.MemEn_SO), 32'h1);
        cyc(0, 3'b100, 8'd11); check("stale_c2_valid", 32'(bus.SramValid_SO), 32'h0);
        check("stale_c2_busy", 32'(bus.Busy_SO), 32'h1);
        cyc(0, 3'b100, 8'd11); check("stale_c3_valid", 32'(bus.SramValid_SO), 32'h0);
        check_hv("stale_im3_kept", bus.IM_mod3_DO, row_word(181, 0));
        cyc(0, 3'b100, 8'd11); check("stale_c4_valid", 32'(bus.SramValid_SO), 32'h4);

        // Fill at channel 20, drop requests, re-raise: valid without a read.
        expect_triple(20);
        cyc(0, 3'b111, 8'd20);
        repeat (5) cyc(0, 3'b111, 8'd20);
        check("ch20_full_valid", 32'(bus.SramValid_SO), 32'h7);
        cyc(0, 3'b000, 8'd20); check("ch20_off_valid", 32'(bus.SramValid_SO), 32'h0);
        cyc(0, 3'b000, 8'd20); check("ch20_off_busy", 32'(bus.Busy_SO), 32'h0);
        exp_row0_q.push_back(20);
        exp_row1_q.push_back(52);
        exp_row2_q.push_back(161);
        cyc(0, 3'b111, 8'd20); check("ch20_reraise_valid", 32'(bus.SramValid_SO), 32'h7);
        check("ch20_reraise_memen", 32'(bus.MemEn_SO), 32'h0);

        // Reset pulse with two reads in flight (rows 30 and 62).
        exp_addr_q.push_back(ADDR_W'(30));
        exp_addr_q.push_back(ADDR_W'(62));
        cyc(0, 3'b111, 8'd30);
        cyc(0, 3'b111, 8'd30);
        cyc(1, 3'b000, 8'd30); check("rst_valid", 32'(bus.SramValid_SO), 32'h0);
        check_hv("rst_im1", bus.IM_mod1_DO, '0);
        check_hv("rst_pos2", bus.ProjPos_mod2_DO, '0);
        check("rst_busy", 32'(bus.Busy_SO), 32'h0);
        cyc(0, 3'b000, 8'd30); check("rst_rel_valid", 32'(bus.SramValid_SO), 32'h0);
        cyc(0, 3'b000, 8'd30); check_hv("rst_drop_im2", bus.IM_mod2_DO, '0);
        check_hv("rst_drop_neg2", bus.ProjNeg_mod2_DO, '0);
        check_hv("rst_drop_im1", bus.IM_mod1_DO, '0);
        check("rst_drop_memen", 32'(bus.MemEn_SO), 32'h0);

        // Recovery after reset: arbitration restarts at modality 1.
        expect_triple(30);
        cyc(0, 3'b111, 8'd30);
        repeat (5) cyc(0, 3'b111, 8'd30);
        check("recover_valid", 32'(bus.SramValid_SO), 32'h7);

        repeat (2) cyc(0, 3'b111, 8'd30);
        check("left_reads", 32'(exp_addr_q.size()), 32'h0);
        check("left_rows", 32'(exp_row0_q.size() + exp_row1_q.size() + exp_row2_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
